// File: rtl/mips_store_buffer.sv
// Posted-store write buffer between a MIPS CPU data port and a memory port.
//
// Stores are accepted in one cycle into a DEPTH-entry FIFO and drained to memory in order.
// Loads go through a small read FSM: a load waits while it is blocked by buffered stores,
// then issues one memory read and returns the data combinationally on completion.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   cpu_address/read/write       CPU access (address bits [1:0] ignored)
//   cpu_writedata/byteenable     store data and lane enables
//   cpu_readdata/waitrequest     load data (zero unless completing) and CPU stall
//   mem_address/read/write       memory request (word-aligned address)
//   mem_writedata/byteenable     memory store data and lanes (4'b1111 on reads)
//   mem_readdata/waitrequest     memory response and stall
//   empty                        high when no store is buffered
//
// Configuration macro STORE_BUF_BYPASS_EN: when defined, a load is blocked only by buffered
// stores to the same word; otherwise every load waits for the buffer to drain completely.
module mips_store_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_address,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_writedata,
    input  logic [3:0]  cpu_byteenable,
    output logic [31:0] cpu_readdata,
    output logic        cpu_waitrequest,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_byteenable,
    input  logic [31:0] mem_readdata,
    input  logic        mem_waitrequest,
    output logic        empty
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StRdWait, StRdIssue} state_e;

    state_e          state_q, state_d;
    logic [29:0]     addr_q [DEPTH];
    logic [31:0]     data_q [DEPTH];
    logic [3:0]      be_q   [DEPTH];
    logic [PtrW-1:0] head_q, tail_q;
    logic [CntW-1:0] count_q, count_d;

    logic not_empty, full, wr_stall, push, pop, rd_blocked, go_issue;
    logic unused_addr_lsbs;

    assign unused_addr_lsbs = ^cpu_address[1:0];

    assign not_empty = (count_q != '0);
    assign full      = (count_q == CntW'(DEPTH));
    // Occupancy at cycle start decides fullness; a same-cycle pop does not free a slot.
    assign wr_stall  = full || (state_q == StRdIssue);
    assign push      = cpu_write && !wr_stall && !rst;
    assign pop       = mem_write && !mem_waitrequest;
    assign count_d   = count_q + CntW'(push) - CntW'(pop);

`ifdef STORE_BUF_BYPASS_EN
    logic [DEPTH-1:0] valid_q;

    always_comb begin
        rd_blocked = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == cpu_address[31:2])) rd_blocked = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            if (pop)  valid_q[head_q] <= 1'b0;
            if (push) valid_q[tail_q] <= 1'b1;
        end
    end
`else
    assign rd_blocked = not_empty;
`endif

    // A read may not take the memory port from a store beat that is still stalled, or the
    // memory-side request would change under waitrequest.
    assign go_issue = !rd_blocked && !(not_empty && mem_waitrequest);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (cpu_read && !cpu_write) state_d = go_issue ? StRdIssue : StRdWait;
            StRdWait:  begin
                if (!cpu_read)     state_d = StIdle;
                else if (go_issue) state_d = StRdIssue;
            end
            StRdIssue: if (!mem_waitrequest) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        cpu_readdata    = 32'h0;
        cpu_waitrequest = 1'b0;
        mem_address     = 32'h0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_writedata   = 32'h0;
        mem_byteenable  = 4'h0;
        empty           = rst || !not_empty;
        if (!rst) begin
            if (state_q == StRdIssue) begin
                mem_read        = 1'b1;
                mem_address     = {cpu_address[31:2], 2'b00};
                mem_byteenable  = 4'hf;
                cpu_waitrequest = cpu_write || mem_waitrequest;
                if (!mem_waitrequest) cpu_readdata = mem_readdata;
            end else begin
                if (not_empty) begin
                    mem_write      = 1'b1;
                    mem_address    = {addr_q[head_q], 2'b00};
                    mem_writedata  = data_q[head_q];
                    mem_byteenable = be_q[head_q];
                end
                // Writes win over reads; a load never completes outside StRdIssue.
                if (cpu_write)     cpu_waitrequest = full;
                else if (cpu_read) cpu_waitrequest = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (push) tail_q <= tail_q + 1'b1;
            if (pop)  head_q <= head_q + 1'b1;
        end
    end

    // Payload storage needs no reset: entries are only visible while counted as occupied.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= cpu_address[31:2];
            data_q[tail_q] <= cpu_writedata;
            be_q[tail_q]   <= cpu_byteenable;
        end
    end

endmodule

// File: tb/tb_mips_store_buffer.sv
module tb_mips_store_buffer;

    localparam int Limit = 400;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_address, cpu_writedata, cpu_readdata;
    logic        cpu_read, cpu_write, cpu_waitrequest;
    logic [3:0]  cpu_byteenable;
    logic [31:0] mem_address, mem_writedata, mem_readdata;
    logic        mem_read, mem_write, mem_waitrequest;
    logic [3:0]  mem_byteenable;
    logic        empty;

    mips_store_buffer #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
        .cpu_readdata(cpu_readdata), .cpu_waitrequest(cpu_waitrequest),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
        .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest),
        .empty(empty)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wait_mode = 0;  // 0: never stall, 1: always stall, 2: random

    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents (the slave) and the reference view of memory once all accepted
    // stores have landed.
    logic [31:0] mem_arr   [1024];
    logic [31:0] model_mem [1024];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } beat_t;
    beat_t exp_q[$];

    int          beat_cyc[$];
    logic [31:0] last_beat_addr;
    int          read_cyc;
    logic        empty_at_read;

    assign mem_readdata = mem_read ? mem_arr[mem_address[11:2]] : 32'h0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Memory stall generator.
    always @(negedge clk) begin
        case (wait_mode)
            0:       mem_waitrequest = 1'b0;
            1:       mem_waitrequest = 1'b1;
            default: mem_waitrequest = ($urandom_range(0, 3) == 0);
        endcase
    end

    // Memory-side monitor and scoreboard.
    logic        prev_stall = 1'b0;
    logic        p_rd, p_wr;
    logic [31:0] p_addr, p_data;
    logic [3:0]  p_be;

    always @(negedge clk) begin
        beat_t e;
        #2;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            check("mem_excl", 32'(mem_read & mem_write), 32'h0);
            if (prev_stall) begin
                check("hold_addr", mem_address, p_addr);
                check("hold_data", mem_writedata, p_data);
                check("hold_ctl", {26'h0, mem_read, mem_write, mem_byteenable},
                      {26'h0, p_rd, p_wr, p_be});
            end
            if (mem_write && !mem_waitrequest) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_write_beat");
                end else begin
                    e = exp_q.pop_front();
                    check("beat_addr", mem_address, e.addr);
                    check("beat_data", mem_writedata, e.data);
                    check("beat_be", {28'h0, mem_byteenable}, {28'h0, e.be});
                end
                mem_arr[mem_address[11:2]] = merge(mem_arr[mem_address[11:2]], mem_writedata,
                                                   mem_byteenable);
                beat_cyc.push_back(cyc);
                last_beat_addr = mem_address;
            end
            if (mem_read && !(prev_stall && p_rd)) begin
                empty_at_read = empty;
                check("read_be", {28'h0, mem_byteenable}, 32'hf);
`ifndef STORE_BUF_BYPASS_EN
                check("read_after_drain", 32'(empty), 32'h1);
`endif
            end
            if (mem_read && !mem_waitrequest) read_cyc = cyc;
            else check("rdata_idle", cpu_readdata, 32'h0);
            prev_stall = (mem_read || mem_write) && mem_waitrequest;
            p_rd = mem_read;
            p_wr = mem_write;
            p_addr = mem_address;
            p_data = mem_writedata;
            p_be = mem_byteenable;
        end
    end

    // CPU driver tasks: entered at a falling edge, return at a falling edge.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                            output int waited);
        bit done;
        done = 0;
        waited = 0;
        cpu_write = 1'b1;
        cpu_address = a;
        cpu_writedata = d;
        cpu_byteenable = be;
        for (int n = 0; n < Limit && !done; n++) begin
            #2;
            if (!cpu_waitrequest) begin
                done = 1;
                exp_q.push_back('{addr: {a[31:2], 2'b00}, data: d, be: be});
                model_mem[a[11:2]] = merge(model_mem[a[11:2]], d, be);
            end else begin
                waited++;
            end
            @(negedge clk);
        end
        cpu_write = 1'b0;
        if (!done) fail_now("store_timeout");
    endtask

    task automatic do_load(input logic [31:0] a, output logic [31:0] d);
        bit done;
        done = 0;
        d = 32'hx;
        cpu_read = 1'b1;
        cpu_address = a;
        for (int n = 0; n < Limit && !done; n++) begin
            #2;
            if (!cpu_waitrequest) begin
                done = 1;
                d = cpu_readdata;
            end
            @(negedge clk);
        end
        cpu_read = 1'b0;
        if (!done) fail_now("load_timeout");
    endtask

    task automatic drain();
        for (int n = 0; n < Limit && exp_q.size() != 0; n++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("drained", exp_q.size(), 32'h0);
        #2;
        check("empty_after_drain", 32'(empty), 32'h1);
        @(negedge clk);
    endtask

    typedef struct {
        bit          ld;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    initial begin
        vec_t        vt[6];
        int          w;
        logic [31:0] d;

        vt[0] = '{ld: 0, addr: 32'h100, data: 32'hA0A0_0001, be: 4'hf, exp: 32'h0};
        vt[1] = '{ld: 0, addr: 32'h104, data: 32'hA0A0_0002, be: 4'hf, exp: 32'h0};
        vt[2] = '{ld: 0, addr: 32'h10B, data: 32'hA0A0_0003, be: 4'hf, exp: 32'h0};
        vt[3] = '{ld: 0, addr: 32'h10C, data: 32'hA0A0_0004, be: 4'hf, exp: 32'h0};
        vt[4] = '{ld: 0, addr: 32'h200, data: 32'hDEAD_BEEF, be: 4'h3, exp: 32'h0};
        vt[5] = '{ld: 1, addr: 32'h202, data: 32'h0, be: 4'h0, exp: 32'h1122_BEEF};

        for (int i = 0; i < 1024; i++) begin
            mem_arr[i] = 32'h5A00_0000 ^ (i * 32'h0001_0203);
            model_mem[i] = mem_arr[i];
        end
        mem_arr[32'h200 >> 2] = 32'h1122_3344;
        model_mem[32'h200 >> 2] = 32'h1122_3344;

        rst = 1'b1;
        cpu_address = 0; cpu_read = 0; cpu_write = 0; cpu_writedata = 0; cpu_byteenable = 0;
        mem_waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        cpu_read = 1'b1;
        #1;
        check("rst_waitreq", 32'(cpu_waitrequest), 32'h0);
        check("rst_empty", 32'(empty), 32'h1);
        cpu_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("init_empty", 32'(empty), 32'h1);
        check("init_mem_write", 32'(mem_write), 32'h0);
        check("init_mem_read", 32'(mem_read), 32'h0);
        check("init_waitreq", 32'(cpu_waitrequest), 32'h0);
        check("init_rdata", cpu_readdata, 32'h0);
        check("init_addr", mem_address, 32'h0);
        @(negedge clk);

        // Directed vectors: back-to-back stores, then a partial store and a load of it.
        beat_cyc.delete();
        for (int i = 0; i < 6; i++) begin
            if (vt[i].ld) begin
                do_load(vt[i].addr, d);
                check("vec_load", d, vt[i].exp);
                check("vec_load_model", d, model_mem[vt[i].addr[11:2]]);
            end else begin
                do_store(vt[i].addr, vt[i].data, vt[i].be, w);
                check("vec_store_nowait", w, 32'h0);
            end
        end
        drain();
        check("b2b_beats", beat_cyc.size(), 32'd5);
        check("b2b_span", beat_cyc[3] - beat_cyc[0], 32'd3);
        check("write_before_read", 32'(beat_cyc[4] < read_cyc), 32'h1);

        // Full buffer: fifth store stalls until the first pop.
        wait_mode = 1;
        @(negedge clk);
        fork
            begin
                for (int i = 0; i < 5; i++)
                    do_store(32'h100 + 32'(i) * 4, 32'hC0DE_0000 + 32'(i), 4'hf, w);
                check("full_stall_cycles", w, 32'd5);
            end
            begin
                repeat (8) @(negedge clk);
                #1;
                wait_mode = 0;
                mem_waitrequest = 1'b0;
            end
        join
        drain();
        check("last_beat_addr", last_beat_addr, 32'h110);
        check("mem_0x110", mem_arr[32'h110 >> 2], 32'hC0DE_0004);

        // Load to another word with two stores pending on a stalled memory.
        wait_mode = 1;
        @(negedge clk);
        do_store(32'h300, 32'h3333_0001, 4'hf, w);
        do_store(32'h300, 32'h3333_0002, 4'hf, w);
        fork
            begin
                do_load(32'h400, d);
                check("bypass_load", d, model_mem[32'h400 >> 2]);
            end
            begin
                repeat (2) @(negedge clk);
                #1;
                wait_mode = 0;
                mem_waitrequest = 1'b0;
            end
        join
`ifdef STORE_BUF_BYPASS_EN
        check("read_ahead_of_store", 32'(empty_at_read), 32'h0);
`else
        check("read_after_stores", 32'(empty_at_read), 32'h1);
`endif
        drain();

        // Read and write together: write wins, no read issued.
        cpu_read = 1'b1; cpu_write = 1'b1; cpu_address = 32'h500;
        cpu_writedata = 32'h5555_AAAA; cpu_byteenable = 4'hf;
        #2;
        check("rw_accept", 32'(cpu_waitrequest), 32'h0);
        check("rw_no_read", 32'(mem_read), 32'h0);
        exp_q.push_back('{addr: 32'h500, data: 32'h5555_AAAA, be: 4'hf});
        model_mem[32'h500 >> 2] = 32'h5555_AAAA;
        @(negedge clk);
        cpu_read = 1'b0; cpu_write = 1'b0;
        #2;
        check("rw_no_read_next", 32'(mem_read), 32'h0);
        @(negedge clk);
        drain();

        // Reset with three stores stuck behind a stalled memory.
        wait_mode = 1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) do_store(32'h600 + 32'(i) * 4, 32'hBAD0_0000 + 32'(i), 4'hf, w);
        rst = 1'b1;
        #1;
        check("rst_mid_empty", 32'(empty), 32'h1);
        check("rst_mid_mem_write", 32'(mem_write), 32'h0);
        check("rst_mid_waitreq", 32'(cpu_waitrequest), 32'h0);
        exp_q.delete();
        for (int i = 0; i < 1024; i++) model_mem[i] = mem_arr[i];
        @(negedge clk);
        rst = 1'b0;
        wait_mode = 0;
        repeat (10) @(negedge clk);
        check("post_rst_mem_0x600", mem_arr[32'h600 >> 2], model_mem[32'h600 >> 2]);
        drain();

        // Random traffic against the memory model.
        wait_mode = 2;
        for (int i = 0; i < 200; i++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0, 1: do_store(a, $urandom, 4'($urandom_range(1, 15)), w);
                2: begin
                    do_load(a, d);
                    check("rand_load", d, model_mem[a[11:2]]);
                end
                default: @(negedge clk);
            endcase
        end
        wait_mode = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mips_store_buffer.md
MIPS_STORE_BUFFER -- requirements
Module: mips_store_buffer

Interface
REQ-001 SHALL have parameter: DEPTH, 4, number of posted-store entries (power of two, 2..16).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: cpu_address  input  32  CPU data-port byte address; bits [1:0] ignored.
REQ-005 SHALL have ports: cpu_read / cpu_write  input  1 each  CPU access strobes.
REQ-006 SHALL have ports: cpu_writedata  input  32, and cpu_byteenable  input  4  store data and lane enables.
REQ-007 SHALL have ports: cpu_readdata  output  32, and cpu_waitrequest  output  1  load data and CPU stall.
REQ-008 SHALL have ports: mem_address  output  32  (word-aligned), mem_read / mem_write  output  1, mem_writedata  output  32, mem_byteenable  output  4.
REQ-009 SHALL have ports: mem_readdata  input  32, and mem_waitrequest  input  1  memory-side response and stall.
REQ-010 SHALL have port: empty  output  1  high when no store is buffered.

Function
REQ-011 SHALL accept a CPU store (cpu_write=1, cpu_waitrequest=0) in one cycle, enqueueing {cpu_address[31:2],2'b00, writedata, byteenable}.
REQ-012 SHALL assert cpu_waitrequest for a store while the occupancy at cycle start equals DEPTH; a same-cycle pop does not free the slot.
REQ-013 SHALL present the oldest entry on the memory side with mem_write=1 whenever non-empty and no read is being issued; entry pops on the cycle mem_write=1 and mem_waitrequest=0.
REQ-014 SHALL keep mem_read and mem_write mutually exclusive; mem outputs SHALL hold stable while mem_waitrequest=1.
REQ-015 SHALL run a read FSM: IDLE -> RD_WAIT on cpu_read when the read is blocked (REQ-016); IDLE/RD_WAIT -> RD_ISSUE when unblocked; RD_ISSUE -> IDLE on mem_waitrequest=0.
REQ-016 SHALL treat a read as blocked while any buffered store exists (default build); stores keep draining in RD_WAIT.
REQ-017 SHALL, in RD_ISSUE, drive mem_read=1, mem_address=cpu_address word-aligned, mem_byteenable=4'b1111, and hold cpu_waitrequest=1 until the cycle mem_waitrequest=0, when cpu_readdata=mem_readdata and cpu_waitrequest=0 combinationally.
REQ-018 SHALL drive cpu_waitrequest=1 for a read in IDLE-blocked, RD_WAIT and RD_ISSUE-with-wait; minimum read latency is 1 cycle (IDLE unblocked -> RD_ISSUE, data next cycle at best).
REQ-019 SHALL give cpu_write priority if cpu_read and cpu_write are both asserted; the read is ignored that cycle.
REQ-020 SHALL drive cpu_readdata=0 outside the read-completion cycle.
REQ-021 SHALL wrap head/tail pointers modulo DEPTH and track occupancy 0..DEPTH; simultaneous enqueue and pop leaves occupancy unchanged.
REQ-022 SHALL not accept a new store while in RD_ISSUE (cpu_waitrequest=1).

Reset
REQ-023 SHALL, on rst=1 at any time, discard all buffered stores, return FSM to IDLE, and drive empty=1, cpu_waitrequest=0, cpu_readdata=0, mem_read=0, mem_write=0, mem_address=0, mem_writedata=0, mem_byteenable=0.
REQ-024 SHALL, on reset mid-transaction, abandon any in-flight memory access with no retry after release.

Configuration
REQ-025 SHALL, when STORE_BUF_BYPASS_EN is defined, block a read only while a buffered entry matches its word address; non-matching reads go to RD_ISSUE ahead of pending stores.
REQ-026 SHALL, when STORE_BUF_BYPASS_EN is undefined, follow REQ-016 (full drain before any read).

Verification
REQ-027 SHALL cover: 4 stores to 0x100..0x10C with mem_waitrequest=0 -> 4 back-to-back mem_write beats in order, empty=1 after the last.
REQ-028 SHALL cover: mem_waitrequest=1 held, 5 stores -> 5th store sees cpu_waitrequest=1 until first pop; data at 0x110 written last.
REQ-029 SHALL cover: store 0xDEADBEEF be=4'b0011 to 0x200 then load 0x200 -> mem_write precedes mem_read; load returns memory word containing 0xBEEF in [15:0].
REQ-030 SHALL cover: STORE_BUF_BYPASS_EN defined, 2 stores to 0x300, load 0x400 -> mem_read issued before either store drains; undefined -> after both.
REQ-031 SHALL cover: rst pulsed with 3 stores buffered and mem_waitrequest=1 -> empty=1, mem_write=0 immediately; no stale beat after release.
REQ-032 SHALL cover: cpu_read and cpu_write together at 0x500 -> store enqueued, no mem_read issued that cycle.
